// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: register file with EX/WB bypass feeding a registered
// ALU operand/control bundle, with stall-hold and flush-bubble control.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validD,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic [XLEN-1:0] immD,
  input  logic            ALUsrcD,
  input  logic [2:0]      ALUcntrlD,
  input  logic            RegWriteD,
  input  logic            stall,
  input  logic            flush,
  input  logic            WE3,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD3,
  input  logic [XLEN-1:0] ALUout,
  output logic [XLEN-1:0] ALUop1,
  output logic [XLEN-1:0] ALUop2,
  output logic [2:0]      ALUcntrl,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            validE,
  output logic [XLEN-1:0] a0
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      ctl_q, ctl_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;

  logic [XLEN-1:0] rs1_stored, rs2_stored;
  logic [XLEN-1:0] src1, src2;
  logic            ex_fwd_en;

  // Priority: x0, then the in-flight EX result, then the WB write, then storage.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] stored,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    if (rs == '0)                  return '0;
    else if (ex_en && ex_rd == rs) return ex_val;
    else if (wb_en && wb_rd == rs) return wb_val;
    else                           return stored;
  endfunction

  always_comb begin
    rf_d = rf_q;
    if (WE3 && (A3 != '0) && (int'(A3) < NREG)) rf_d[A3] = WD3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rs1_stored = (int'(rs1D) < NREG) ? rf_q[rs1D] : '0;
    rs2_stored = (int'(rs2D) < NREG) ? rf_q[rs2D] : '0;
    ex_fwd_en  = valid_q && regwrite_q;
    src1 = resolve(rs1D, rs1_stored, ex_fwd_en, rd_q, ALUout, WE3, A3, WD3);
    src2 = resolve(rs2D, rs2_stored, ex_fwd_en, rd_q, ALUout, WE3, A3, WD3);
  end

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    ctl_d      = ctl_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    if (flush || (!stall && !validD)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      ctl_d      = '0;
      op1_d      = '0;
      op2_d      = '0;
    end else if (!stall) begin
      valid_d    = 1'b1;
      regwrite_d = RegWriteD;
      rd_d       = rdD;
      ctl_d      = ALUcntrlD;
      op1_d      = src1;
      op2_d      = ALUsrcD ? immD : src2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      ctl_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      ctl_q      <= ctl_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
    end
  end

  assign ALUop1    = op1_q;
  assign ALUop2    = op2_q;
  assign ALUcntrl  = ctl_q;
  assign RdE       = rd_q;
  assign RegWriteE = regwrite_q;
  assign validE    = valid_q;
  assign a0        = rf_q[10];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench: directed vector table, reset sequence, then random
// stimulus against a behavioural model of the operand stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validD, ALUsrcD, RegWriteD, stall, flush, WE3;
  logic [4:0]  rs1D, rs2D, rdD, A3;
  logic [31:0] immD, WD3, ALUout;
  logic [2:0]  ALUcntrlD;
  logic [31:0] ALUop1, ALUop2, a0;
  logic [2:0]  ALUcntrl;
  logic [4:0]  RdE;
  logic        RegWriteE, validE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .rdD(rdD), .immD(immD), .ALUsrcD(ALUsrcD), .ALUcntrlD(ALUcntrlD),
    .RegWriteD(RegWriteD), .stall(stall), .flush(flush), .WE3(WE3),
    .A3(A3), .WD3(WD3), .ALUout(ALUout), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .ALUcntrl(ALUcntrl), .RdE(RdE), .RegWriteE(RegWriteE), .validE(validE),
    .a0(a0)
  );

  typedef struct {
    logic        vd;
    logic [4:0]  r1, r2, rd;
    logic [31:0] imm;
    logic        src;
    logic [2:0]  ctl;
    logic        rw, st, fl, we;
    logic [4:0]  a3;
    logic [31:0] wd, alu;
    logic [31:0] e_op1, e_op2;
    logic [2:0]  e_ctl;
    logic [4:0]  e_rd;
    logic        e_rw, e_v;
    logic [31:0] e_a0;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(
    input logic vd, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
    input logic [31:0] imm, input logic src, input logic [2:0] ctl, input logic rw,
    input logic st, input logic fl, input logic we, input logic [4:0] a3,
    input logic [31:0] wd, input logic [31:0] alu,
    input logic [31:0] e_op1, input logic [31:0] e_op2, input logic [2:0] e_ctl,
    input logic [4:0] e_rd, input logic e_rw, input logic e_v, input logic [31:0] e_a0);
    vec_t v;
    v.vd = vd; v.r1 = r1; v.r2 = r2; v.rd = rd; v.imm = imm; v.src = src;
    v.ctl = ctl; v.rw = rw; v.st = st; v.fl = fl; v.we = we; v.a3 = a3;
    v.wd = wd; v.alu = alu; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_ctl = e_ctl;
    v.e_rd = e_rd; v.e_rw = e_rw; v.e_v = e_v; v.e_a0 = e_a0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [2:0] ctl, input logic [4:0] rd, input logic rw,
                           input logic v, input logic [31:0] ea0);
    check({tag, ".ALUop1"},    ALUop1,           op1);
    check({tag, ".ALUop2"},    ALUop2,           op2);
    check({tag, ".ALUcntrl"},  {29'd0, ALUcntrl}, {29'd0, ctl});
    check({tag, ".RdE"},       {27'd0, RdE},      {27'd0, rd});
    check({tag, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, rw});
    check({tag, ".validE"},    {31'd0, validE},   {31'd0, v});
    check({tag, ".a0"},        a0,               ea0);
  endtask

  task automatic apply(input vec_t v);
    validD = v.vd; rs1D = v.r1; rs2D = v.r2; rdD = v.rd; immD = v.imm;
    ALUsrcD = v.src; ALUcntrlD = v.ctl; RegWriteD = v.rw; stall = v.st;
    flush = v.fl; WE3 = v.we; A3 = v.a3; WD3 = v.wd; ALUout = v.alu;
  endtask

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        m_v, m_rw;
  logic [4:0]  m_rd;
  logic [2:0]  m_ctl;
  logic [31:0] m_op1, m_op2;

  function automatic logic [31:0] m_src(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (m_v && m_rw && m_rd == rs) return ALUout;
    if (WE3 && A3 == rs) return WD3;
    return m_rf[rs];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [31:0] s1, s2;
    s1 = m_src(rs1D);
    s2 = ALUsrcD ? immD : m_src(rs2D);
    if (flush || (!stall && !validD)) begin
      m_v = 0; m_rw = 0; m_rd = 0; m_ctl = 0; m_op1 = 0; m_op2 = 0;
    end else if (!stall) begin
      m_v = 1; m_rw = RegWriteD; m_rd = rdD; m_ctl = ALUcntrlD; m_op1 = s1; m_op2 = s2;
    end
    if (WE3 && A3 != 0) m_rf[A3] = WD3;
  endtask

  initial begin
    //             vd r1  r2 rd  imm           src ctl rw st fl we a3  wd        alu        op1       op2           ctl rd rw v  a0
    tbl[0]  = mk(0, 0,  0, 0,  32'h0,        0, 0, 0, 0, 0, 1, 5,  32'h1234, 32'h0,     32'h0,    32'h0,        0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 5,  0, 10, 32'h10,       1, 3, 1, 0, 0, 1, 3,  32'h11,   32'h0,     32'h1234, 32'h10,       3, 10,1, 1, 32'h0);
    tbl[2]  = mk(1, 0,  7, 0,  32'h0,        0, 1, 1, 0, 0, 1, 7,  32'hAA,   32'h999,   32'h0,    32'hAA,       1, 0, 1, 1, 32'h0);
    tbl[3]  = mk(1, 0,  0, 3,  32'hFFFFFFFF, 1, 7, 1, 0, 0, 1, 0,  32'h5,    32'h999,   32'h0,    32'hFFFFFFFF, 7, 3, 1, 1, 32'h0);
    tbl[4]  = mk(1, 3,  3, 10, 32'h0,        0, 2, 1, 0, 0, 1, 3,  32'h22,   32'h55,    32'h55,   32'h55,       2, 10,1, 1, 32'h0);
    tbl[5]  = mk(1, 3,  7, 4,  32'h0,        0, 5, 0, 0, 0, 1, 10, 32'hDEAD, 32'hBEEF,  32'h22,   32'hAA,       5, 4, 0, 1, 32'hDEAD);
    tbl[6]  = mk(1, 5,  5, 9,  32'h3,        1, 6, 1, 1, 0, 1, 12, 32'h77,   32'h0,     32'h22,   32'hAA,       5, 4, 0, 1, 32'hDEAD);
    tbl[7]  = mk(0, 1,  2, 3,  32'h4,        0, 1, 1, 1, 0, 0, 0,  32'h0,    32'h0,     32'h22,   32'hAA,       5, 4, 0, 1, 32'hDEAD);
    tbl[8]  = mk(1, 12, 0, 1,  32'h8,        1, 6, 1, 0, 0, 0, 0,  32'h0,    32'h0,     32'h77,   32'h8,        6, 1, 1, 1, 32'hDEAD);
    tbl[9]  = mk(1, 5,  5, 5,  32'h9,        0, 3, 1, 1, 1, 0, 0,  32'h0,    32'h0,     32'h0,    32'h0,        0, 0, 0, 0, 32'hDEAD);
    tbl[10] = mk(1, 10, 5, 2,  32'h0,        0, 4, 1, 0, 0, 0, 0,  32'h0,    32'h0,     32'hDEAD, 32'h1234,     4, 2, 1, 1, 32'hDEAD);
    tbl[11] = mk(0, 5,  5, 5,  32'h1,        1, 2, 1, 0, 0, 0, 0,  32'h0,    32'hDEAD,  32'h0,    32'h0,        0, 0, 0, 0, 32'hDEAD);

    rst_n = 1'b0;
    apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    #12;
    check_all("reset", 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_ctl,
                tbl[i].e_rd, tbl[i].e_rw, tbl[i].e_v, tbl[i].e_a0);
    end

    // Asynchronous reset between edges, with a write presented while held.
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    WE3 = 1'b1; A3 = 5'd10; WD3 = 32'hFFFF; validD = 1'b1; rs1D = 5'd10;
    @(posedge clk); #1;
    check("rst_hold.a0", a0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; WE3 = 1'b0; validD = 1'b1; rs1D = 5'd10; ALUsrcD = 1'b1;
    immD = 32'h0; ALUcntrlD = 3'd0; rdD = 5'd0; RegWriteD = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst", 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_v = 1; m_rw = 0; m_rd = 0; m_ctl = 0; m_op1 = 0; m_op2 = 0;

    for (int n = 0; n < 600; n++) begin
      validD    = ($urandom_range(0, 9) != 0);
      rs1D      = 5'($urandom_range(0, 7));
      rs2D      = 5'($urandom_range(0, 7));
      rdD       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      immD      = $urandom;
      ALUsrcD   = 1'($urandom_range(0, 1));
      ALUcntrlD = 3'($urandom_range(0, 7));
      RegWriteD = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      WE3       = 1'($urandom_range(0, 1));
      A3        = ($urandom_range(0, 5) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      WD3       = $urandom;
      ALUout    = $urandom;
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_op1, m_op2, m_ctl, m_rd, m_rw, m_v, m_rf[10]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
